// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge: FT232H async-245 FIFO bridge with valid/ready RX/TX streams and an RX buffer.
// Optional FTDI_RR_ARB_EN selects round-robin read/write arbitration instead of fixed read priority.
module ftdi_fifo_bridge #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4,
  parameter int RD_LOW   = 4,
  parameter int WR_SETUP = 1,
  parameter int WR_LOW   = 3,
  parameter int WR_HOLD  = 1,
  parameter int RECOVER  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rxf,
  input  logic                        txe,
  input  logic [DATA_W-1:0]           adbus_in,
  output logic [DATA_W-1:0]           adbus_out,
  output logic                        adbus_tri,
  output logic                        ftdi_rd,
  output logic                        ftdi_wr,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        busy
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int NW = 16;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WSET, S_WLOW, S_WHOLD, S_RECOV} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [1:0] rxf_sync_q, txe_sync_q;
  logic rd_q, rd_d, wr_q, wr_d, tri_q, tri_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic rxf_s, txe_s, rd_req, wr_req, rd_win, last, push, pop;
  assign rxf_s  = rxf_sync_q[1];
  assign txe_s  = txe_sync_q[1];
  assign rd_req = !rxf_s && count_q != (AW+1)'(RX_DEPTH);
  assign wr_req = !txe_s && tx_valid;
  assign last   = cnt_q == NW'(1);
  assign pop    = rx_valid && rx_ready;
`ifdef FTDI_RR_ARB_EN
  logic last_wr_q, last_wr_d, wr_done;
  assign wr_done = state_q == S_WHOLD && last;
  assign rd_win  = rd_req && (!wr_req || last_wr_q);
  always_comb last_wr_d = push ? 1'b0 : wr_done ? 1'b1 : last_wr_q;
  always_ff @(posedge clock) last_wr_q <= reset ? 1'b1 : last_wr_d;
`else
  assign rd_win = rd_req;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q - NW'(1);
    rd_d     = rd_q;
    wr_d     = wr_q;
    tri_d    = tri_q;
    out_d    = out_q;
    tx_ready = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (rd_win) begin
          state_d = S_RD;
          rd_d    = 1'b0;
          cnt_d   = NW'(RD_LOW);
        end else if (wr_req) begin
          tx_ready = 1'b1;
          state_d  = S_WSET;
          tri_d    = 1'b1;
          out_d    = tx_data;
          cnt_d    = NW'(WR_SETUP);
        end
      end
      S_RD: if (last) begin
        state_d = S_RECOV;
        rd_d    = 1'b1;
        push    = 1'b1;
        cnt_d   = NW'(RECOVER);
      end
      S_WSET: if (last) begin
        state_d = S_WLOW;
        wr_d    = 1'b0;
        cnt_d   = NW'(WR_LOW);
      end
      S_WLOW: if (last) begin
        state_d = S_WHOLD;
        wr_d    = 1'b1;
        cnt_d   = NW'(WR_HOLD);
      end
      S_WHOLD: if (last) begin
        state_d = S_RECOV;
        tri_d   = 1'b0;
        cnt_d   = NW'(RECOVER);
      end
      S_RECOV: if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      tri_q      <= 1'b0;
      out_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rxf_sync_q <= 2'b11;
      txe_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tri_q      <= tri_d;
      out_q      <= out_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rxf_sync_q <= {rxf_sync_q[0], rxf};
      txe_sync_q <= {txe_sync_q[0], txe};
    end
  end
  always_ff @(posedge clock) if (push) mem_q[wptr_q] <= adbus_in;
  assign adbus_out = out_q;
  assign adbus_tri = tri_q;
  assign ftdi_rd   = rd_q;
  assign ftdi_wr   = wr_q;
  assign rx_data   = mem_q[rptr_q];
  assign rx_valid  = count_q != '0;
  assign rx_count  = count_q;
  assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// tb_ftdi_fifo_bridge: directed scenarios plus random traffic checked against a transfer-timeline model.
// Build with FTDI_RR_ARB_EN defined to check the round-robin arbitration variant.
module tb_ftdi_fifo_bridge;
  localparam int DW = 8, D = 4, RDL = 4, WS = 1, WL = 3, WH = 1, RC = 3;
  logic clock = 0, reset = 1, rxf = 1, txe = 1, rx_ready = 0, tx_valid = 0;
  logic [DW-1:0] adbus_in = '0, tx_data = '0;
  logic [DW-1:0] adbus_out, rx_data;
  logic adbus_tri, ftdi_rd, ftdi_wr, rx_valid, tx_ready, busy;
  logic [$clog2(D):0] rx_count;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;

  ftdi_fifo_bridge #(.DATA_W(DW), .RX_DEPTH(D), .RD_LOW(RDL), .WR_SETUP(WS), .WR_LOW(WL),
                     .WR_HOLD(WH), .RECOVER(RC)) dut (
    .clock(clock), .reset(reset), .rxf(rxf), .txe(txe), .adbus_in(adbus_in),
    .adbus_out(adbus_out), .adbus_tri(adbus_tri), .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_count(rx_count), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: op 0 idle, 1 read, 2 write; ph counts cycles since the transfer was granted.
  bit armed = 0;
  int op = 0, ph = 0;
  bit rs1 = 1, rs2 = 1, ts1 = 1, ts2 = 1, last_wr = 1;
  logic [DW-1:0] wbyte = '0;
  logic [DW-1:0] q[$];

  always @(negedge clock) begin
    bit rdq, wrq, rdw, wrg, pop;
    rdq = !rs2 && q.size() < D;
    wrq = !ts2 && tx_valid;
`ifdef FTDI_RR_ARB_EN
    rdw = rdq && (!wrq || last_wr);
`else
    rdw = rdq;
`endif
    wrg = op == 0 && wrq && !rdw;
    if (armed) begin
      chk("ftdi_rd", ftdi_rd, !(op == 1 && ph <= RDL));
      chk("ftdi_wr", ftdi_wr, !(op == 2 && ph > WS && ph <= WS + WL));
      chk("adbus_tri", adbus_tri, op == 2 && ph <= WS + WL + WH);
      chk("adbus_out", adbus_out, wbyte);
      chk("busy", busy, op != 0);
      chk("rx_valid", rx_valid, q.size() > 0);
      chk("rx_count", rx_count, q.size());
      if (q.size() > 0) chk("rx_data", rx_data, q[0]);
      chk("tx_ready", tx_ready, wrg);
      if (!ftdi_rd && adbus_tri) chk("rd_tri_exclusive", 1, 0);
    end
    if (reset) begin
      op = 0; ph = 0; q.delete(); wbyte = '0; last_wr = 1;
      rs1 = 1; rs2 = 1; ts1 = 1; ts2 = 1; armed = 1;
    end else begin
      pop = q.size() > 0 && rx_ready;
      if (pop) void'(q.pop_front());
      if (op == 0) begin
        if (rdw) begin op = 1; ph = 1; end
        else if (wrq) begin op = 2; ph = 1; wbyte = tx_data; end
      end else begin
        if (op == 1 && ph == RDL) begin q.push_back(adbus_in); last_wr = 0; end
        if (op == 2 && ph == WS + WL + WH) last_wr = 1;
        if (ph == (op == 1 ? RDL + RC : WS + WL + WH + RC)) begin op = 0; ph = 0; end
        else ph++;
      end
      rs2 = rs1; rs1 = rxf; ts2 = ts1; ts1 = txe;
    end
  end

  int reads = 0;
  logic prev_rd = 1, prev_tri = 0;
  task automatic run_reads(input int cyc);
    repeat (cyc) begin
      @(negedge clock);
      if (!prev_rd && ftdi_rd) reads++;
      prev_rd = ftdi_rd;
      @(posedge clock); #1;
      adbus_in = DW'(reads);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int n, lo, k, tri_cnt;
    int ops[4];
    int exp_ops[4];
`ifdef FTDI_RR_ARB_EN
    exp_ops = '{0, 1, 0, 1};
`else
    exp_ops = '{0, 0, 0, 0};
`endif
    reset = 1; rxf = 0; txe = 0; adbus_in = 8'hA5;
    repeat (3) begin
      @(negedge clock);
      chk("rst_ftdi_rd", ftdi_rd, 1);
      chk("rst_ftdi_wr", ftdi_wr, 1);
      chk("rst_tri", adbus_tri, 0);
      chk("rst_rx_valid", rx_valid, 0);
    end
    tick(1);
    reset = 0;
    n = 0;
    do begin @(negedge clock); n++; end while (ftdi_rd && n < 4);
    chk("rd_fall_within_3", ftdi_rd, 0);
    lo = 0;
    while (!ftdi_rd && lo < 10) begin lo++; @(negedge clock); end
    chk("rd_low_cycles", lo, 4);
    chk("rd_rx_valid", rx_valid, 1);
    chk("rd_rx_data", rx_data, 8'hA5);
    chk("rd_rx_count", rx_count, 1);
    tick(1);
    rxf = 1; rx_ready = 1;
    tick(1);
    rx_ready = 0;
    tick(10);
    tx_data = 8'h3C; tx_valid = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!adbus_tri && n < 10);
    chk("wr_tri_on", adbus_tri, 1);
    chk("wr_out", adbus_out, 8'h3C);
    chk("wr_setup_wr_high", ftdi_wr, 1);
    tick(1);
    tx_valid = 0;
    @(negedge clock);
    lo = 0;
    while (!ftdi_wr && lo < 10) begin lo++; @(negedge clock); end
    chk("wr_low_cycles", lo, 3);
    chk("wr_hold_tri", adbus_tri, 1);
    @(negedge clock);
    chk("wr_tri_off", adbus_tri, 0);
    tick(1);
    txe = 1; adbus_in = '0; rxf = 0; reads = 0; prev_rd = 1;
    run_reads(60);
    chk("fill_reads", reads, 4);
    chk("fill_count", rx_count, 4);
    chk("fill_head", rx_data, 8'h00);
    chk("fill_rd_idle", ftdi_rd, 1);
    rx_ready = 1;
    tick(1);
    rx_ready = 0;
    run_reads(30);
    chk("pop_reads", reads, 5);
    chk("pop_count", rx_count, 4);
    chk("pop_head", rx_data, 8'h01);
    reset = 1; rxf = 0; txe = 0; tx_valid = 1; rx_ready = 1; tx_data = 8'h77;
    tick(3);
    reset = 0;
    n = 0; k = 0; prev_rd = 1; prev_tri = 0;
    while (n < 4 && k < 300) begin
      @(negedge clock);
      k++;
      if (prev_rd && !ftdi_rd && n < 4) begin ops[n] = 0; n++; end
      if (!prev_tri && adbus_tri && n < 4) begin ops[n] = 1; n++; end
      prev_rd = ftdi_rd; prev_tri = adbus_tri;
    end
    chk("arb_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_op%0d", i), ops[i], exp_ops[i]);
    tick(1);
    tx_valid = 0; rxf = 1;
    tick(20);
    txe = 0; tx_data = 8'h5A; tx_valid = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!adbus_tri && n < 10);
    chk("rstw_tri_on", adbus_tri, 1);
    tick(1);
    tx_valid = 0;
    n = 0;
    do begin @(negedge clock); n++; end while (ftdi_wr && n < 10);
    chk("rstw_wr_low", ftdi_wr, 0);
    tick(1);
    reset = 1;
    @(negedge clock);
    chk("rstw_pre_edge_wr", ftdi_wr, 0);
    @(negedge clock);
    chk("rstw_wr", ftdi_wr, 1);
    chk("rstw_tri", adbus_tri, 0);
    chk("rstw_busy", busy, 0);
    tick(1);
    reset = 0;
    tri_cnt = 0;
    repeat (20) begin @(negedge clock); if (adbus_tri) tri_cnt++; end
    chk("rstw_no_resend", tri_cnt, 0);
    tick(1);
    for (int i = 0; i < 3000; i++) begin
      reset    = $urandom_range(0, 299) == 0;
      rxf      = $urandom_range(0, 3) == 0 ? ~rxf : rxf;
      txe      = $urandom_range(0, 3) == 0 ? ~txe : txe;
      tx_valid = $urandom_range(0, 1) == 1;
      tx_data  = DW'($urandom);
      adbus_in = DW'($urandom);
      rx_ready = $urandom_range(0, 9) < (i < 1500 ? 2 : 7);
      tick(1);
    end
    reset = 0;
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
